// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared types and constants for the memory port arbiter.
//
// Contents:
//   DEF_DATA_W / DEF_ADDR_W / DEF_STARVE_LIMIT : default parameter values
//   arb_state_t : 2-bit FSM state encoding (IDLE, IF_XFER, DM_XFER, RESP)
//   owner_t     : which requester owns the transaction in flight
//   cnt_width() : bit width needed to count 0..limit inclusive
package mem_arb_pkg;

   localparam int DEF_DATA_W       = 32;
   localparam int DEF_ADDR_W       = 32;
   localparam int DEF_STARVE_LIMIT = 3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_IF_XFER = 2'd1,
      ST_DM_XFER = 2'd2,
      ST_RESP    = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

   // Width of a counter that must hold every value 0..limit.
   function automatic int cnt_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if -- bundle of the arbiter's fetch, data and memory
// signals, for environments that want to pass the whole port set around.
//
// Handshake: a requester raises *_req with its command fields and holds all
// of them stable until the matching one-cycle *_done pulse; a req still high
// in the cycle after done is a fresh transaction. Toward memory, mem_req and
// the command fields are stable until the one-cycle mem_ack pulse.
//
// Modports:
//   slave  : the arbiter's view (requests and memory response in)
//   master : the environment's view (core ports and memory model)
interface mem_port_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_done;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_done;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic              pipe_stall;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
      output if_rdata, if_done, dm_rdata, dm_done,
      output mem_req, mem_we, mem_addr, mem_wdata, pipe_stall
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
      input  if_rdata, if_done, dm_rdata, dm_done,
      input  mem_req, mem_we, mem_addr, mem_wdata, pipe_stall
   );

endinterface

// File: rtl/arb_starve_counter.sv
// arb_starve_counter -- saturating count of data grants made while fetch waits.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one data grant (ignored once saturated)
//   clr        : a fetch grant; wins over inc
//   cnt        : current count, 0..LIMIT
//   at_limit   : cnt == LIMIT, fetch must win the next contested grant
module arb_starve_counter
   import mem_arb_pkg::*;
#(
   parameter  int LIMIT = DEF_STARVE_LIMIT,
   localparam int CNT_W = cnt_width(LIMIT)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             at_limit
);

   localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

   assign at_limit = (cnt == LIMIT_V);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !at_limit) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter -- shares one backing-memory port between instruction
// fetch and the MEM stage, one transaction at a time.
//
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-low reset
//   if_*                : fetch request (req/addr in, rdata/done out)
//   dm_*                : data request (req/we/addr/wdata in, rdata/done out)
//   mem_*               : shared memory command out, rdata/ack in
//   pipe_stall_o        : pipeline freeze while any request is unserved
//   dbg_state           : FSM state (arb_state_t encoding)
//   dbg_starve_cnt      : current starvation count
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter  int DATA_W       = DEF_DATA_W,
   parameter  int ADDR_W       = DEF_ADDR_W,
   parameter  int STARVE_LIMIT = DEF_STARVE_LIMIT,
   localparam int STARVE_W     = cnt_width(STARVE_LIMIT)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                if_req_i,
   input  logic [ADDR_W-1:0]   if_addr_i,
   output logic [DATA_W-1:0]   if_rdata_o,
   output logic                if_done_o,
   input  logic                dm_req_i,
   input  logic                dm_we_i,
   input  logic [ADDR_W-1:0]   dm_addr_i,
   input  logic [DATA_W-1:0]   dm_wdata_i,
   output logic [DATA_W-1:0]   dm_rdata_o,
   output logic                dm_done_o,
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   input  logic [DATA_W-1:0]   mem_rdata_i,
   input  logic                mem_ack_i,
   output logic                pipe_stall_o,
   output logic [1:0]          dbg_state,
   output logic [STARVE_W-1:0] dbg_starve_cnt
);

   arb_state_t        state_q, state_d;
   owner_t            owner_q;
   logic              grant_if, grant_dm;
   logic              in_xfer, ack_xfer;
   logic              starve_at_limit;
   logic              cmd_we_q;
   logic [ADDR_W-1:0] cmd_addr_q;
   logic [DATA_W-1:0] cmd_wdata_q;
   logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;

   arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
      .clk      (clk_i),
      .rst_n    (rst_i),
      .inc      (grant_dm & if_req_i),
      .clr      (grant_if),
      .cnt      (dbg_starve_cnt),
      .at_limit (starve_at_limit)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Data wins a contested grant unless fetch has already waited through
   // STARVE_LIMIT data grants.
   always_comb begin
      state_d  = state_q;
      grant_if = 1'b0;
      grant_dm = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (dm_req_i && !(if_req_i && starve_at_limit)) begin
               grant_dm = 1'b1;
               state_d  = ST_DM_XFER;
            end else if (if_req_i) begin
               grant_if = 1'b1;
               state_d  = ST_IF_XFER;
            end
         end
         ST_IF_XFER, ST_DM_XFER: begin
            if (mem_ack_i) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign in_xfer  = (state_q == ST_IF_XFER) || (state_q == ST_DM_XFER);
   // An ack outside a transfer carries no meaning and is dropped here.
   assign ack_xfer = in_xfer && mem_ack_i;

   // Command registers and owner are loaded only on a grant, so the memory
   // command stays frozen for the whole transfer.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         owner_q     <= OWN_IF;
         cmd_we_q    <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
      end else if (grant_dm) begin
         owner_q     <= OWN_DM;
         cmd_we_q    <= dm_we_i;
         cmd_addr_q  <= dm_addr_i;
         cmd_wdata_q <= dm_wdata_i;
      end else if (grant_if) begin
         owner_q     <= OWN_IF;
         cmd_we_q    <= 1'b0;
         cmd_addr_q  <= if_addr_i;
         cmd_wdata_q <= '0;
      end
   end

   // Read data lands in the owning port's register; writes leave both alone.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else if (ack_xfer && !cmd_we_q) begin
         if (state_q == ST_IF_XFER) begin
            if_rdata_q <= mem_rdata_i;
         end else begin
            dm_rdata_q <= mem_rdata_i;
         end
      end
   end

   assign mem_req_o    = in_xfer;
   assign mem_we_o     = cmd_we_q;
   assign mem_addr_o   = cmd_addr_q;
   assign mem_wdata_o  = cmd_wdata_q;
   assign if_rdata_o   = if_rdata_q;
   assign dm_rdata_o   = dm_rdata_q;
   // Done is decoded from RESP plus a single owner bit, so both can never be high.
   assign if_done_o    = (state_q == ST_RESP) && (owner_q == OWN_IF);
   assign dm_done_o    = (state_q == ST_RESP) && (owner_q == OWN_DM);
   assign pipe_stall_o = (if_req_i & ~if_done_o) | (dm_req_i & ~dm_done_o);
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter -- directed self-checking bench for mem_port_arbiter.
// Inputs are driven and outputs sampled on the falling clock edge. A memory
// responder acks after a programmable number of transfer cycles and checks
// each command against an expected queue; stray acks are injected by hand.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic clk;
   logic rst_i;
   logic [1:0] dbg_state;
   logic [1:0] dbg_starve_cnt;

   mem_port_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

   mem_port_arbiter dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .if_req_i       (bus.if_req),
      .if_addr_i      (bus.if_addr),
      .if_rdata_o     (bus.if_rdata),
      .if_done_o      (bus.if_done),
      .dm_req_i       (bus.dm_req),
      .dm_we_i        (bus.dm_we),
      .dm_addr_i      (bus.dm_addr),
      .dm_wdata_i     (bus.dm_wdata),
      .dm_rdata_o     (bus.dm_rdata),
      .dm_done_o      (bus.dm_done),
      .mem_req_o      (bus.mem_req),
      .mem_we_o       (bus.mem_we),
      .mem_addr_o     (bus.mem_addr),
      .mem_wdata_o    (bus.mem_wdata),
      .mem_rdata_i    (bus.mem_rdata),
      .mem_ack_i      (bus.mem_ack),
      .pipe_stall_o   (bus.pipe_stall),
      .dbg_state      (dbg_state),
      .dbg_starve_cnt (dbg_starve_cnt)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [95:0] exp_q[$];

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [95:0] cmd_pack(input logic we, input logic [31:0] a, input logic [31:0] d);
      return {31'd0, we, a, d};
   endfunction

   // ---------------- memory responder ----------------
   logic        auto_mem = 1'b0;
   int          ack_delay = 1;
   logic [31:0] rd_word = '0;
   logic        resp_ack = 1'b0;
   logic [31:0] resp_rdata = '0;
   logic        man_ack = 1'b0;
   logic [31:0] man_rdata = '0;

   assign bus.mem_ack   = resp_ack | man_ack;
   assign bus.mem_rdata = man_ack ? man_rdata : resp_rdata;

   always begin : responder
      int wait_cnt;
      wait_cnt = 0;
      forever begin
         @(negedge clk);
         resp_ack = 1'b0;
         if (auto_mem && rst_i && bus.mem_req) begin
            wait_cnt++;
            if (wait_cnt == ack_delay) begin
               resp_ack   = 1'b1;
               resp_rdata = rd_word;
               wait_cnt   = 0;
               if (exp_q.size() == 0) begin
                  check("cmd_unexpected", cmd_pack(bus.mem_we, bus.mem_addr, bus.mem_wdata), '0);
               end else begin
                  check("mem_cmd", cmd_pack(bus.mem_we, bus.mem_addr, bus.mem_wdata), exp_q.pop_front());
               end
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   int both_seen = 0;
   int dm_pulses = 0;
   int if_pulses = 0;
   always @(negedge clk) begin
      if (bus.if_done && bus.dm_done) both_seen++;
      if (bus.dm_done) dm_pulses++;
      if (bus.if_done) if_pulses++;
   end

   // ---------------- driver tasks ----------------
   // Runs a fixed window of cycles, dropping each req on its done pulse and
   // reporting the cycle (1 = first falling edge after launch) of each done.
   task automatic wait_done(input int budget, output int if_at, output int dm_at);
      if_at = 0;
      dm_at = 0;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         if (bus.if_done && if_at == 0) begin
            if_at = c;
            bus.if_req = 1'b0;
         end
         if (bus.dm_done && dm_at == 0) begin
            dm_at = c;
            bus.dm_req = 1'b0;
         end
      end
   endtask

   task automatic idle_inputs();
      bus.if_req   = 1'b0;
      bus.if_addr  = '0;
      bus.dm_req   = 1'b0;
      bus.dm_we    = 1'b0;
      bus.dm_addr  = '0;
      bus.dm_wdata = '0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int if_at, dm_at, dm_cnt, max_cnt, snap_if, snap_dm;
      bit seen_if;
      idle_inputs();
      rst_i = 1'b1;
      #1 rst_i = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_state", 96'(dbg_state), 96'(ST_IDLE));
      check("rst_mem_req", 96'(bus.mem_req), 96'd0);
      check("rst_if_rdata", 96'(bus.if_rdata), 96'd0);
      check("rst_dm_rdata", 96'(bus.dm_rdata), 96'd0);
      check("rst_done", 96'({bus.if_done, bus.dm_done}), 96'd0);
      rst_i = 1'b1;
      @(negedge clk);

      // Fetch only, ack on the 2nd transfer cycle: done lands in the 4th
      // cycle counting the request cycle as the 1st.
      auto_mem  = 1'b1;
      ack_delay = 2;
      rd_word   = 32'h0051_3023;
      exp_q.push_back(cmd_pack(1'b0, 32'h0000_0010, 32'h0));
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h0000_0010;
      #1 check("f_stall_req", 96'(bus.pipe_stall), 96'd1);
      wait_done(8, if_at, dm_at);
      check("f_done_cycle", 96'(if_at), 96'd3);
      check("f_if_rdata", 96'(bus.if_rdata), 96'h0051_3023);
      check("f_stall_idle", 96'(bus.pipe_stall), 96'd0);

      // Data read alone, ack on the 1st transfer cycle (minimum latency)
      ack_delay = 1;
      rd_word   = 32'hCAFE_F00D;
      exp_q.push_back(cmd_pack(1'b0, 32'h20, 32'h0));
      bus.dm_req  = 1'b1;
      bus.dm_we   = 1'b0;
      bus.dm_addr = 32'h20;
      wait_done(6, if_at, dm_at);
      check("r_done_cycle", 96'(dm_at), 96'd2);
      check("r_dm_rdata", 96'(bus.dm_rdata), 96'hCAFE_F00D);

      // Simultaneous: data write first, then fetch; write leaves dm_rdata
      rd_word = 32'h1234_5678;
      exp_q.push_back(cmd_pack(1'b1, 32'h40, 32'hDEAD_BEEF));
      exp_q.push_back(cmd_pack(1'b0, 32'h80, 32'h0));
      bus.dm_req   = 1'b1;
      bus.dm_we    = 1'b1;
      bus.dm_addr  = 32'h40;
      bus.dm_wdata = 32'hDEAD_BEEF;
      bus.if_req   = 1'b1;
      bus.if_addr  = 32'h80;
      wait_done(8, if_at, dm_at);
      check("s_dm_done_cycle", 96'(dm_at), 96'd2);
      check("s_if_done_cycle", 96'(if_at), 96'd5);
      check("s_dm_rdata_kept", 96'(bus.dm_rdata), 96'hCAFE_F00D);
      check("s_if_rdata", 96'(bus.if_rdata), 96'h1234_5678);
      check("s_starve_clr", 96'(dbg_starve_cnt), 96'd0);

      // Starvation: data held high with fetch pending -> 3 data, then fetch
      rd_word = 32'h0BAD_CAFE;
      repeat (3) exp_q.push_back(cmd_pack(1'b0, 32'h100, 32'h0));
      exp_q.push_back(cmd_pack(1'b0, 32'h200, 32'h0));
      bus.dm_req   = 1'b1;
      bus.dm_we    = 1'b0;
      bus.dm_addr  = 32'h100;
      bus.dm_wdata = '0;
      bus.if_req   = 1'b1;
      bus.if_addr  = 32'h200;
      dm_cnt  = 0;
      max_cnt = 0;
      seen_if = 1'b0;
      for (int c = 0; c < 40 && !seen_if; c++) begin
         @(negedge clk);
         if (int'(dbg_starve_cnt) > max_cnt) max_cnt = int'(dbg_starve_cnt);
         if (bus.dm_done) dm_cnt++;
         if (bus.if_done) begin
            seen_if    = 1'b1;
            bus.if_req = 1'b0;
            bus.dm_req = 1'b0;
         end
      end
      check("st_fetch_served", 96'(seen_if), 96'd1);
      check("st_dm_grants", 96'(dm_cnt), 96'd3);
      check("st_max_cnt", 96'(max_cnt), 96'd3);
      check("st_cnt_cleared", 96'(dbg_starve_cnt), 96'd0);
      check("st_q_empty", 96'(exp_q.size()), 96'd0);
      check("st_if_rdata", 96'(bus.if_rdata), 96'h0BAD_CAFE);
      @(negedge clk);

      // Stray ack in IDLE
      auto_mem  = 1'b0;
      snap_if   = if_pulses;
      snap_dm   = dm_pulses;
      man_rdata = 32'hFFFF_FFFF;
      man_ack   = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      repeat (2) @(negedge clk);
      check("sa_state", 96'(dbg_state), 96'(ST_IDLE));
      check("sa_no_done", 96'((if_pulses - snap_if) + (dm_pulses - snap_dm)), 96'd0);
      check("sa_if_rdata", 96'(bus.if_rdata), 96'h0BAD_CAFE);
      check("sa_dm_rdata", 96'(bus.dm_rdata), 96'h0BAD_CAFE);

      // Reset during DM_XFER, then a late ack
      bus.dm_req   = 1'b1;
      bus.dm_we    = 1'b1;
      bus.dm_addr  = 32'h44;
      bus.dm_wdata = 32'h5555_AAAA;
      @(negedge clk);
      check("rx_in_xfer", 96'({dbg_state, bus.mem_req, bus.mem_we}), 96'({ST_DM_XFER, 1'b1, 1'b1}));
      rst_i = 1'b0;
      #1;
      check("rx_state", 96'(dbg_state), 96'(ST_IDLE));
      check("rx_mem_cmd", cmd_pack(bus.mem_we, bus.mem_addr, bus.mem_wdata), '0);
      check("rx_mem_req", 96'(bus.mem_req), 96'd0);
      check("rx_rdata", 96'({bus.if_rdata, bus.dm_rdata}), 96'd0);
      idle_inputs();
      snap_dm = dm_pulses;
      @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      man_rdata = 32'h7777_7777;
      man_ack   = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      repeat (2) @(negedge clk);
      check("rx_late_ack_done", 96'(dm_pulses - snap_dm), 96'd0);
      check("rx_late_ack_state", 96'(dbg_state), 96'(ST_IDLE));
      check("rx_late_ack_rdata", 96'(bus.dm_rdata), 96'd0);

      check("done_exclusive", 96'(both_seen), 96'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
